// File: rtl/mac_datapath.sv
// Coefficient x operand multiply-accumulate with rounding and saturation. Result registers on the band_listo edge.
// Latency: 1 cycle from the band_listo step. Backpressure: none; a strobe pattern is accepted every cycle.
module mac_datapath #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int NCOEF = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sel_const,
  input  logic [1:0]       sel_fun,
  input  logic             sel_acum,
  input  logic             band_listo,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] u_in,
  input  logic             coef_we,
  input  logic [2:0]       coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  output logic             ovf_out
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] P_MAX = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] P_MIN = ~P_MAX;
  localparam logic [WIDTH-1:0]     W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] coef [NCOEF];
  logic signed [WIDTH-1:0] x_reg, u_reg, acc;
  logic signed [WIDTH-1:0] coef_sel, opnd, term, next_acc;
  logic signed [PW-1:0]    prod, rnd;
  logic signed [WIDTH:0]   sum;
  logic                    ovf_sticky, prod_sat, acc_sat, sat_now, ovf_next;

  always_comb begin
    coef_sel = '0;
    if (32'(sel_const) < NCOEF) coef_sel = coef[sel_const];
  end

  always_comb begin
    case (sel_fun)
      2'd0:    opnd = x_reg;
      2'd1:    opnd = u_reg;
      2'd2:    opnd = $signed(y_out);
      default: opnd = '0;
    endcase
  end

  // Full-width product cannot overflow PW bits, so round and shift there before clamping.
  assign prod     = PW'(coef_sel) * PW'(opnd);
  assign rnd      = (prod + HALF) >>> FRAC;
  assign prod_sat = (rnd > P_MAX) || (rnd < P_MIN);

  always_comb begin
    term = rnd[WIDTH-1:0];
    if (rnd > P_MAX)      term = W_MAX;
    else if (rnd < P_MIN) term = W_MIN;
  end

  assign sum     = {acc[WIDTH-1], acc} + {term[WIDTH-1], term};
  assign acc_sat = sel_acum && (sum[WIDTH] != sum[WIDTH-1]);

  always_comb begin
    next_acc = term;
    if (sel_acum) begin
      if (acc_sat) next_acc = sum[WIDTH] ? W_MIN : W_MAX;
      else         next_acc = sum[WIDTH-1:0];
    end
  end

  assign sat_now  = prod_sat | acc_sat;
  assign ovf_next = sat_now | (sel_acum & ovf_sticky);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
      x_reg      <= '0;
      u_reg      <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      y_out      <= '0;
      y_valid    <= 1'b0;
      ovf_out    <= 1'b0;
    end else begin
      if (coef_we && (32'(coef_addr) < NCOEF)) coef[coef_addr] <= coef_data;
      if (sample_en) begin
        x_reg <= x_in;
        u_reg <= u_in;
      end
      acc        <= next_acc;
      ovf_sticky <= ovf_next;
      y_valid    <= band_listo;
      if (band_listo) begin
        y_out   <= next_acc;
        ovf_out <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_mac_datapath.sv
// Directed bench for mac_datapath: integer reference model compared every cycle plus literal result table.
module tb_mac_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel_const, coef_addr;
  logic [1:0]  sel_fun;
  logic        sel_acum, band_listo, sample_en, coef_we;
  logic [15:0] x_in, u_in, coef_data;
  logic [15:0] y_out;
  logic        y_valid, ovf_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mac_datapath dut (
    .clk(clk), .reset(reset), .sel_const(sel_const), .sel_fun(sel_fun),
    .sel_acum(sel_acum), .band_listo(band_listo), .sample_en(sample_en),
    .x_in(x_in), .u_in(u_in), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .y_out(y_out), .y_valid(y_valid), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model in plain integers, Q8.8 interpretation.
  longint mcoef [6];
  longint mx, mu, macc, my;
  bit     mvld, movf, mstk, mready = 1'b0;

  function automatic longint clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    longint c, f, t, s;
    bit     sn;
    if (reset) begin
      for (int i = 0; i < 6; i++) mcoef[i] = 0;
      mx = 0; mu = 0; macc = 0; my = 0;
      mvld = 0; movf = 0; mstk = 0; mready = 1;
    end else begin
      c = (sel_const < 6) ? mcoef[sel_const] : 0;
      case (sel_fun)
        2'd0:    f = mx;
        2'd1:    f = mu;
        2'd2:    f = my;
        default: f = 0;
      endcase
      t  = (c * f + 128) >>> 8;
      sn = (t != clamp(t));
      t  = clamp(t);
      s  = sel_acum ? macc + t : t;
      sn = sn | (s != clamp(s));
      s  = clamp(s);
      sn = sn | (sel_acum && mstk);
      if (coef_we && coef_addr < 6) mcoef[coef_addr] = longint'($signed(coef_data));
      if (sample_en) begin
        mx = longint'($signed(x_in));
        mu = longint'($signed(u_in));
      end
      macc = s;
      mstk = sn;
      mvld = band_listo;
      if (band_listo) begin
        my   = s;
        movf = sn;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [15:0] ey;
    if (mready) begin
      ey = my[15:0];
      checks++;
      if (y_out !== ey || y_valid !== mvld || ovf_out !== movf) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d got y=%h v=%b o=%b exp y=%h v=%b o=%b",
                 cyc, y_out, y_valid, ovf_out, ey, mvld, movf);
      end
    end
  end

  logic [15:0] ev_y [$];
  bit          ev_o [$];
  int          ev_c [$];

  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      ev_y.push_back(y_out);
      ev_o.push_back(ovf_out);
      ev_c.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] f, input logic a, input logic bl,
                       input logic se, input logic [15:0] x, input logic [15:0] u,
                       input logic we, input logic [2:0] ad, input logic [15:0] d,
                       input logic r);
    sel_const = c; sel_fun = f; sel_acum = a; band_listo = bl;
    sample_en = se; x_in = x; u_in = u;
    coef_we = we; coef_addr = ad; coef_data = d; reset = r;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] ad, input logic [15:0] d);
    drive(3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, ad, d, 1'b0);
  endtask

  task automatic smp(input logic [15:0] x, input logic [15:0] u);
    drive(3'd0, 2'd3, 1'b0, 1'b0, 1'b1, x, u, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic seq6();
    logic [1:0] fs [6];
    fs = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++)
      drive(3'(i), fs[i], (i != 0), (i == 5), 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  logic [15:0] exp_y [13];
  bit          exp_o [13];

  initial begin
    exp_y = '{16'h0000, 16'h0400, 16'h0500, 16'h7FFF, 16'h0200, 16'h0001, 16'h0000,
              16'hFFFF, 16'h7FFF, 16'h4000, 16'h0000, 16'h0400, 16'h0600};
    exp_o = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    // Reset held two cycles with random strobes and data.
    for (int i = 0; i < 2; i++)
      drive(3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'b1);
    chk("reset_y", 32'(y_out), 32'h0);
    chk("reset_valid", 32'(y_valid), 32'h0);
    chk("reset_ovf", 32'(ovf_out), 32'h0);

    // Zero coefficients after reset.
    smp(16'h0200, 16'h0400);
    seq6();

    // Basic sequence then immediate feedback sequence.
    wr(3'd0, 16'h0100); wr(3'd1, 16'h0080); wr(3'd2, 16'h0040);
    wr(3'd6, 16'h1234);
    seq6();
    seq6();
    idle();

    // Product saturation, then clean sequence clears ovf.
    wr(3'd0, 16'h7F00); wr(3'd1, 16'h0000); wr(3'd2, 16'h0000);
    smp(16'h7F00, 16'h0400);
    seq6();
    wr(3'd0, 16'h0100);
    smp(16'h0200, 16'h0400);
    seq6();

    // Rounding half-up.
    wr(3'd0, 16'h0001);
    smp(16'h0080, 16'h0000); seq6();
    smp(16'hFF80, 16'h0000); seq6();
    smp(16'hFF00, 16'h0000); seq6();

    // Accumulator saturation, then a one-step sequence.
    wr(3'd0, 16'h4000); wr(3'd1, 16'h4000);
    smp(16'h0100, 16'h0100);
    seq6();
    drive(3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);

    // Reset during step 4 aborts the sequence and clears acc.
    for (int i = 0; i < 3; i++)
      drive(3'(i), 2'(i % 3), (i != 0), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    drive(3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("midreset_y", 32'(y_out), 32'h0);
    chk("midreset_valid", 32'(y_valid), 32'h0);
    drive(3'd3, 2'd3, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);

    // Coefficient write colliding with its read.
    wr(3'd0, 16'h0100); wr(3'd2, 16'h0100);
    smp(16'h0200, 16'h0400);
    drive(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    drive(3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 3'd2, 16'h0200, 1'b0);
    drive(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    drive(3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    idle(); idle();

    chk("event_count", 32'(ev_y.size()), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < ev_y.size()) begin
        chk($sformatf("ev%0d_y", i), 32'(ev_y[i]), 32'(exp_y[i]));
        chk($sformatf("ev%0d_ovf", i), 32'(ev_o[i]), 32'(exp_o[i]));
      end
    end
    if (ev_c.size() >= 3) chk("feedback_spacing", 32'(ev_c[2] - ev_c[1]), 32'd6);
    else chk("feedback_spacing_events", 32'(ev_c.size()), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
